pixel_stream_source: RTL and testbench
======================================

Name: pixel_stream_source

Overview:
- Frame-buffered pixel transmitter that drives the feature-extraction pipeline's pixel input interface: `start_signal`, `pixel_valid`, and 8-bit `pixel`.
- A host loads a 32x32 8-bit image into on-chip RAM, then issues `go`.
- The block pulses `start_signal`, streams the pixels in raster order with programmable inter-pixel gaps, and waits for the downstream `final_done_signal`.
- It then reports `frame_done`, or `timeout_err` if the downstream done never arrives.

Parameters:
- IMG_WIDTH, 32, pixels per row.
- IMG_HEIGHT, 32, rows per frame.
- GAP_CYCLES, 0, idle cycles inserted between consecutive valid pixels (0 = back-to-back).
- DONE_TIMEOUT, 4096, max cycles to wait for `ds_done` after the last pixel.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- wr_en  in  1  host write strobe into frame RAM
- wr_addr  in  $clog2(IMG_WIDTH*IMG_HEIGHT)  host write address (raster index)
- wr_data  in  8  host write pixel
- go  in  1  start-frame command
- ds_done  in  1  downstream done pulse (connected to `final_done_signal`)
- start_signal  out  1  one-cycle frame-start pulse to downstream
- pixel_valid  out  1  pixel qualifier
- pixel_out  out  8  pixel value
- busy  out  1  high from accepted `go` until `frame_done`
- frame_done  out  1  one-cycle completion pulse
- timeout_err  out  1  sticky; set on timeout, cleared by next accepted `go`

Behaviour:
- **Reset:** one clock (`clk`); reset is synchronous and active-low, on port `rst`. While `rst`=0 at a clock edge:
  - state <= IDLE;
  - all outputs 0 (`start_signal`, `pixel_valid`, `pixel_out`, `busy`, `frame_done`, `timeout_err`);
  - counters 0.
  - RAM contents are not cleared.
  - Reset mid-stream aborts immediately; no further `pixel_valid` after the reset edge.
- **Frame RAM:** N = IMG_WIDTH*IMG_HEIGHT entries, 1-cycle synchronous read.
  - Writes are accepted only in IDLE; `wr_en` in any other state is ignored.
  - `wr_addr` >= N is ignored.
- **States:** IDLE, START, STREAM, GAP, WAIT_DONE, DONE.
- **IDLE:**
  - `go`=1 -> START; `busy` <= 1; `timeout_err` <= 0; read address <= 0.
  - `go` and `wr_en` in the same cycle: the write completes and `go` is accepted.
  - The write is visible to the frame (RAM write-first at address level not required; the write lands before address 0 is read two cycles later).
- **START:**
  - `start_signal`=1 for exactly this cycle.
  - RAM read of address 0 is issued.
  - -> STREAM.
- **STREAM:**
  - Registered RAM output drives `pixel_out` with `pixel_valid`=1 for one cycle.
  - Pixel index increments.
  - If the pixel index was N-1 -> WAIT_DONE.
  - Else if GAP_CYCLES>0 -> GAP.
  - Else stay in STREAM; the next read is issued in the same cycle.
- **GAP:**
  - `pixel_valid`=0, `pixel_out` holds its last value.
  - Stays GAP_CYCLES cycles; the read for the next pixel is issued on the final GAP cycle.
  - -> STREAM.
- **Latency:** with `go` sampled at edge T:
  - `start_signal` high in cycle T+1;
  - pixel k valid in cycle T+2+k*(GAP_CYCLES+1);
  - exactly N valid cycles per frame.
- **WAIT_DONE:**
  - `pixel_valid`=0.
  - Timeout counter increments each cycle.
  - `ds_done`=1 -> DONE.
  - Counter reaching DONE_TIMEOUT-1 with no `ds_done` -> DONE, with `timeout_err` <= 1.
  - `ds_done` arriving while still in STREAM/GAP is latched and honoured on entry to WAIT_DONE, i.e. WAIT_DONE lasts one cycle.
- **DONE:**
  - `frame_done`=1 for one cycle; `busy` <= 0.
  - -> IDLE.
  - `go` is ignored in DONE and in every state except IDLE. No queuing.
- **Counters:** pixel index width $clog2(N); gap counter width $clog2(GAP_CYCLES+1) (minimum 1); timeout counter width $clog2(DONE_TIMEOUT).

Decomposition:
- Shared package `npu_pkg`:
  - `PIX_W`=8;
  - state enum `src_state_t`;
  - `IMG_WIDTH`/`IMG_HEIGHT` defaults, shared with the 30x30 post-convolution constants.
- Sub-module `frame_ram`:
  - single-port write, single-port read;
  - synchronous read, 1-cycle latency;
  - inferred block RAM, parameterized depth/width.
- The FSM and counters stay in `pixel_stream_source`.

Test Plan:
- Load ram[i] = i mod 256, GAP_CYCLES=0, `go` at T -> `start_signal` at T+1 only; `pixel_out`=0,1,...,255,0,... valid in cycles T+2..T+1025 with no holes; `ds_done` at T+1030 -> `frame_done` at T+1031, `busy` low from T+1032.
- GAP_CYCLES=2, same image -> `pixel_valid` pattern 1,0,0 repeating; pixel 5 (value 5) in cycle T+17; exactly 1024 valid cycles.
- `ds_done` never asserted, DONE_TIMEOUT=16 -> `frame_done` 16 cycles after entering WAIT_DONE; `timeout_err`=1 and remaining 1 until next `go`.
- `go` pulsed and `wr_en` to addr 5 with 0xAA during STREAM -> no second `start_signal`, frame data unchanged (pixel 5 = 5), next frame after reload shows the original RAM (write ignored).
- `rst`=0 asserted at pixel 300 -> next cycle all outputs 0, state IDLE; new `go` restarts from pixel 0 with unchanged RAM contents.
- `ds_done` pulsed during STREAM at pixel 500 -> WAIT_DONE lasts 1 cycle, `frame_done` 2 cycles after last pixel, `timeout_err`=0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared constants and types for the NPU front end: pixel width, image geometry
// (input frame and post-convolution frame) and the pixel source state encoding.
package npu_pkg;

    localparam int PIX_W       = 8;
    localparam int IMG_WIDTH   = 32;
    localparam int IMG_HEIGHT  = 32;
    localparam int CONV_WIDTH  = IMG_WIDTH - 2;
    localparam int CONV_HEIGHT = IMG_HEIGHT - 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        GAP,
        WAIT_DONE,
        DONE
    } src_state_t;

    // Counter width helper: never narrower than one bit.
    function automatic int clog2w(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port
// with a single cycle of latency, written so it maps onto block RAM.
module frame_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_stream_source.sv
// Frame-buffered pixel transmitter: host loads the frame RAM, then on go the
// block pulses start, streams pixels in raster order and waits for ds_done.
module pixel_stream_source
    import npu_pkg::*;
#(
    parameter int IMG_WIDTH    = npu_pkg::IMG_WIDTH,
    parameter int IMG_HEIGHT   = npu_pkg::IMG_HEIGHT,
    parameter int GAP_CYCLES   = 0,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   wr_en,
    input  logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] wr_addr,
    input  logic [PIX_W-1:0]                       wr_data,
    input  logic                                   go,
    input  logic                                   ds_done,
    output logic                                   start_signal,
    output logic                                   pixel_valid,
    output logic [PIX_W-1:0]                       pixel_out,
    output logic                                   busy,
    output logic                                   frame_done,
    output logic                                   timeout_err
);

    localparam int N  = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW = $clog2(N);
    localparam int GW = clog2w(GAP_CYCLES + 1);
    localparam int TW = clog2w(DONE_TIMEOUT);

    localparam logic [AW-1:0] LAST_PIX = AW'(N - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TW-1:0] TO_LAST  = TW'(DONE_TIMEOUT - 1);

    src_state_t       state;
    src_state_t       next_state;
    logic [AW-1:0]    pix_idx;
    logic [AW-1:0]    rd_addr;
    logic [GW-1:0]    gap_cnt;
    logic [TW-1:0]    to_cnt;
    logic             ds_seen;
    logic [PIX_W-1:0] last_pix;
    logic [PIX_W-1:0] ram_q;
    logic             rd_en;
    logic             ram_we;
    logic             done_hit;

    assign ram_we   = wr_en && (state == IDLE) && (32'(wr_addr) < N);
    assign done_hit = ds_done || ds_seen;

    frame_ram #(
        .DEPTH (N),
        .WIDTH (PIX_W)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        rd_en        = 1'b0;
        start_signal = (state == START);
        pixel_valid  = (state == STREAM);
        frame_done   = (state == DONE);
        // Outside STREAM the output holds the last transmitted pixel.
        pixel_out    = (state == STREAM) ? ram_q : last_pix;
        case (state)
            IDLE: begin
                if (go) begin
                    next_state = START;
                end
            end
            START: begin
                rd_en      = 1'b1;
                next_state = STREAM;
            end
            STREAM: begin
                if (pix_idx == LAST_PIX) begin
                    next_state = WAIT_DONE;
                end else if (GAP_CYCLES > 0) begin
                    next_state = GAP;
                end else begin
                    rd_en = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    rd_en      = 1'b1;
                    next_state = STREAM;
                end
            end
            WAIT_DONE: begin
                if (done_hit || (to_cnt == TO_LAST)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pix_idx     <= '0;
            rd_addr     <= '0;
            gap_cnt     <= '0;
            to_cnt      <= '0;
            ds_seen     <= 1'b0;
            last_pix    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
            end
            // An early downstream done is remembered until WAIT_DONE consumes it.
            if (ds_done && ((state == START) || (state == STREAM) || (state == GAP))) begin
                ds_seen <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (go) begin
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        rd_addr     <= '0;
                        pix_idx     <= '0;
                        gap_cnt     <= '0;
                        to_cnt      <= '0;
                        ds_seen     <= 1'b0;
                    end
                end
                STREAM: begin
                    last_pix <= ram_q;
                    pix_idx  <= pix_idx + AW'(1);
                    gap_cnt  <= '0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
                WAIT_DONE: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (!done_hit && (to_cnt == TO_LAST)) begin
                        timeout_err <= 1'b1;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source: two instances (back-to-back with a
// short timeout, and a 2-cycle gap), with a cycle-stamped pixel scoreboard.
module tb_pixel_stream_source;
    import npu_pkg::*;

    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int AW    = $clog2(N);
    localparam int GAP_A = 0;
    localparam int TO_A  = 16;
    localparam int GAP_B = 2;
    localparam int TO_B  = 4096;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_pix_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en_a = 1'b0;
    logic          wr_en_b = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic          go_a = 1'b0;
    logic          go_b = 1'b0;
    logic          ds_done = 1'b0;

    logic       start_a, pv_a, busy_a, done_a, terr_a;
    logic [7:0] pix_a;
    logic       start_b, pv_b, busy_b, done_b, terr_b;
    logic [7:0] pix_b;

    int         cyc = 0;
    int         pass_cnt = 0;
    int         check_cnt = 0;
    int         starts_a = 0;
    int         starts_b = 0;
    int         t0;
    int         s0;
    exp_pix_t   sb_a[$];
    exp_pix_t   sb_b[$];
    exp_pix_t   ea;
    exp_pix_t   eb;
    logic [7:0] img_a [N];
    logic [7:0] img_b [N];

    pixel_stream_source #(
        .GAP_CYCLES   (GAP_A),
        .DONE_TIMEOUT (TO_A)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en_a),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go_a),
        .ds_done      (ds_done),
        .start_signal (start_a),
        .pixel_valid  (pv_a),
        .pixel_out    (pix_a),
        .busy         (busy_a),
        .frame_done   (done_a),
        .timeout_err  (terr_a)
    );

    pixel_stream_source #(
        .GAP_CYCLES   (GAP_B),
        .DONE_TIMEOUT (TO_B)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en_b),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .go           (go_b),
        .ds_done      (ds_done),
        .start_signal (start_b),
        .pixel_valid  (pv_b),
        .pixel_out    (pix_b),
        .busy         (busy_b),
        .frame_done   (done_b),
        .timeout_err  (terr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Pixels must appear exactly when and as the scoreboard predicts.
    always @(negedge clk) begin
        if (start_a) starts_a++;
        if (start_b) starts_b++;
        if (pv_a) begin
            checkOutput("a_sb_nonempty", 32'(sb_a.size() > 0), 32'd1);
            if (sb_a.size() > 0) begin
                ea = sb_a.pop_front();
                checkOutput("a_pix_cyc", 32'(cyc), 32'(ea.cyc));
                checkOutput("a_pix_val", 32'(pix_a), 32'(ea.val));
            end
        end
        if (pv_b) begin
            checkOutput("b_sb_nonempty", 32'(sb_b.size() > 0), 32'd1);
            if (sb_b.size() > 0) begin
                eb = sb_b.pop_front();
                checkOutput("b_pix_cyc", 32'(cyc), 32'(eb.cyc));
                checkOutput("b_pix_val", 32'(pix_b), 32'(eb.val));
            end
        end
    end

    task automatic loadImage();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en_a  = 1'b1;
            wr_en_b  = 1'b1;
            wr_addr  = AW'(i);
            wr_data  = 8'(i);
            img_a[i] = 8'(i);
            img_b[i] = 8'(i);
        end
        @(negedge clk);
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // Issue go on one instance (optionally writing address 0 in the same
    // cycle) and queue the expected cycle/value of every pixel of the frame.
    task automatic applyStimulus(input int sel, input logic wr0, input logic [7:0] wdat,
                                 output int t);
        int gap;
        @(negedge clk);
        t = cyc;
        if (sel == 0) begin
            go_a = 1'b1;
            gap  = GAP_A;
        end else begin
            go_b = 1'b1;
            gap  = GAP_B;
            if (wr0) begin
                wr_en_b  = 1'b1;
                wr_addr  = '0;
                wr_data  = wdat;
                img_b[0] = wdat;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (sel == 0) sb_a.push_back('{t + 2 + k * (gap + 1), img_a[k]});
            else          sb_b.push_back('{t + 2 + k * (gap + 1), img_b[k]});
        end
        @(negedge clk);
        go_a    = 1'b0;
        go_b    = 1'b0;
        wr_en_b = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs_a", 32'({start_a, pv_a, pix_a, busy_a, done_a, terr_a}), 32'd0);
        checkOutput("reset_outputs_b", 32'({start_b, pv_b, pix_b, busy_b, done_b, terr_b}), 32'd0);
        rst = 1'b1;
        loadImage();

        // Back-to-back frame, downstream done well before the timeout.
        applyStimulus(0, 1'b0, 8'h00, t0);
        checkOutput("t1_start_high", 32'(start_a), 32'd1);
        checkOutput("t1_busy_high", 32'(busy_a), 32'd1);
        waitUntil(t0 + 2);
        checkOutput("t1_start_low", 32'(start_a), 32'd0);
        waitUntil(t0 + 1030);
        ds_done = 1'b1;
        waitUntil(t0 + 1031);
        ds_done = 1'b0;
        checkOutput("t1_frame_done", 32'(done_a), 32'd1);
        checkOutput("t1_busy_in_done", 32'(busy_a), 32'd1);
        waitUntil(t0 + 1032);
        checkOutput("t1_busy_low", 32'(busy_a), 32'd0);
        checkOutput("t1_done_pulse", 32'(done_a), 32'd0);
        checkOutput("t1_sb_drained", 32'(sb_a.size()), 32'd0);
        checkOutput("t1_start_count", 32'(starts_a), 32'd1);
        checkOutput("t1_no_timeout", 32'(terr_a), 32'd0);

        // No downstream done: timeout after 16 WAIT_DONE cycles, sticky error.
        applyStimulus(0, 1'b0, 8'h00, t0);
        waitUntil(t0 + 1041);
        checkOutput("t2_not_yet_done", 32'(done_a), 32'd0);
        checkOutput("t2_not_yet_err", 32'(terr_a), 32'd0);
        waitUntil(t0 + 1042);
        checkOutput("t2_timeout_done", 32'(done_a), 32'd1);
        checkOutput("t2_timeout_err", 32'(terr_a), 32'd1);
        waitUntil(t0 + 1043);
        checkOutput("t2_busy_low", 32'(busy_a), 32'd0);
        waitUntil(t0 + 1060);
        checkOutput("t2_err_sticky", 32'(terr_a), 32'd1);

        // Next go clears the error; go and a write during STREAM are ignored.
        s0 = starts_a;
        applyStimulus(0, 1'b0, 8'h00, t0);
        checkOutput("t3_err_cleared", 32'(terr_a), 32'd0);
        waitUntil(t0 + 3);
        go_a    = 1'b1;
        wr_en_a = 1'b1;
        wr_addr = AW'(5);
        wr_data = 8'hAA;
        waitUntil(t0 + 4);
        go_a    = 1'b0;
        wr_en_a = 1'b0;
        waitUntil(t0 + 7);
        checkOutput("t4_pixel5", 32'(pix_a), 32'd5);
        waitUntil(t0 + 1030);
        ds_done = 1'b1;
        waitUntil(t0 + 1031);
        ds_done = 1'b0;
        waitUntil(t0 + 1033);
        checkOutput("t4_single_start", 32'(starts_a), 32'(s0 + 1));
        checkOutput("t4_sb_drained", 32'(sb_a.size()), 32'd0);
        checkOutput("t4_idle_after", 32'(busy_a), 32'd0);

        // Reset at pixel 300 aborts the frame.
        applyStimulus(0, 1'b0, 8'h00, t0);
        waitUntil(t0 + 302);
        rst = 1'b0;
        waitUntil(t0 + 303);
        rst = 1'b1;
        checkOutput("t5_outputs_zero", 32'({start_a, pv_a, pix_a, busy_a, done_a, terr_a}), 32'd0);
        sb_a.delete();
        repeat (6) @(negedge clk);
        checkOutput("t5_stays_idle", 32'({pv_a, busy_a}), 32'd0);

        // Restart from pixel 0; ds_done during STREAM at pixel 500 is latched.
        applyStimulus(0, 1'b0, 8'h00, t0);
        waitUntil(t0 + 502);
        ds_done = 1'b1;
        waitUntil(t0 + 503);
        ds_done = 1'b0;
        waitUntil(t0 + 1026);
        checkOutput("t6_wait_one_cycle", 32'(done_a), 32'd0);
        waitUntil(t0 + 1027);
        checkOutput("t6_early_done", 32'(done_a), 32'd1);
        checkOutput("t6_no_timeout", 32'(terr_a), 32'd0);
        waitUntil(t0 + 1028);
        checkOutput("t6_busy_low", 32'(busy_a), 32'd0);
        checkOutput("t6_sb_drained", 32'(sb_a.size()), 32'd0);

        // Gap of 2 on instance b, with a write to address 0 in the go cycle.
        applyStimulus(1, 1'b1, 8'h5A, t0);
        checkOutput("t7_start_high", 32'(start_b), 32'd1);
        waitUntil(t0 + 3);
        checkOutput("t7_gap_invalid", 32'(pv_b), 32'd0);
        checkOutput("t7_gap_hold", 32'(pix_b), 32'h5A);
        waitUntil(t0 + 17);
        checkOutput("t7_pixel5_valid", 32'(pv_b), 32'd1);
        checkOutput("t7_pixel5_val", 32'(pix_b), 32'd5);
        waitUntil(t0 + 3075);
        ds_done = 1'b1;
        waitUntil(t0 + 3076);
        ds_done = 1'b0;
        checkOutput("t7_frame_done", 32'(done_b), 32'd1);
        waitUntil(t0 + 3077);
        checkOutput("t7_busy_low", 32'(busy_b), 32'd0);
        checkOutput("t7_sb_drained", 32'(sb_b.size()), 32'd0);
        checkOutput("t7_start_count", 32'(starts_b), 32'd1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
